// File: rtl/hist_pkg.sv
// ---------------------------------------------------------------------------
// hist_pkg : shared widths, FSM encoding and bin-count type for the histogram
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package hist_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INC_RD   = 3'd1,
    ST_INC_WR   = 3'd2,
    ST_HOST_RD  = 3'd3,
    ST_HOST_RSP = 3'd4,
    ST_CLEAR    = 3'd5
  } hist_state_e;

  typedef logic [DATA_W_DEF-1:0] bin_cnt_t;

endpackage

`default_nettype wire

// File: rtl/hist_inc_fifo.sv
// ---------------------------------------------------------------------------
// hist_inc_fifo : small synchronous FIFO with flush, head-of-queue output
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hist_inc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hist_bin_ctrl.sv
// ---------------------------------------------------------------------------
// hist_bin_ctrl : histogram RAM owner - buffered RMW increments, host readout,
//                 full-memory clear. HIST_SAT_EN: saturate bins at all-ones.
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module hist_bin_ctrl
  import hist_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_valid,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       drop_cnt
);

  hist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              clr_pend_q, clr_pend_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [15:0]       drop_q, drop_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] fifo_head;
  logic [DATA_W-1:0] inc_val;

`ifdef HIST_SAT_EN
  assign inc_val = (mem_rdata == '1) ? mem_rdata : mem_rdata + DATA_W'(1);
`else
  assign inc_val = mem_rdata + DATA_W'(1);
`endif

  assign fifo_push = inc_valid && (state_q != ST_CLEAR) && !fifo_flush;

  hist_inc_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .din_i   (inc_addr),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    clr_pend_d = clr_pend_q | (clr_req && (state_q != ST_CLEAR));
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    drop_d     = drop_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // An increment arriving this cycle lands in the FIFO at the edge, so it
        // already outranks a simultaneous host read.
        if (clr_pend_q) begin
          state_d    = ST_CLEAR;
          ptr_d      = '0;
          fifo_flush = 1'b1;
        end else if (!fifo_empty || inc_valid) begin
          state_d = ST_INC_RD;
        end else if (rd_req) begin
          state_d = ST_HOST_RD;
          addr_d  = rd_addr;
        end
      end
      ST_INC_RD: begin
        fifo_pop = 1'b1;
        mem_en   = 1'b1;
        mem_addr = fifo_head;
        addr_d   = fifo_head;
        state_d  = ST_INC_WR;
      end
      ST_INC_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = inc_val;
        state_d   = ST_IDLE;
      end
      ST_HOST_RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        state_d  = ST_HOST_RSP;
      end
      ST_HOST_RSP: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_CLEAR: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ptr_q;
        ptr_d    = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) begin
          clr_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifo_push && fifo_full && !fifo_pop && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      clr_pend_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      clr_pend_q <= clr_pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      drop_q     <= drop_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign clr_busy = clr_pend_q;
  assign drop_cnt = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_hist_bin_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hist_bin_ctrl : directed bench for hist_bin_ctrl with a behavioural RAM
// Revision         : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hist_bin_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc_valid;
  logic [7:0]  inc_addr;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        clr_req;
  logic        clr_busy;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hist_bin_ctrl #(.ADDR_W(8), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_valid (inc_valid),
    .inc_addr  (inc_addr),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .drop_cnt  (drop_cnt)
  );

  // Behavioural single-port RAM with a side port for preloading bins.
  logic [15:0] ram [256];
  logic        pl_en = 1'b0, pl_zero = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_zero) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [15:0] d, output bit got);
    got = 1'b0; d = 'x;
    @(negedge clk); rd_req = 1'b1; rd_addr = a;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin got = 1'b1; d = rd_data; rd_req = 1'b0; end
    end
    rd_req = 1'b0;
  endtask

  task automatic wait_quiet(output bit ok);
    int quiet;
    quiet = 0; ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      quiet = (mem_en === 1'b0 && clr_busy === 1'b0) ? quiet + 1 : 0;
      if (quiet >= 2) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inc_valid = 0; inc_addr = '0; rd_req = 0; rd_addr = '0; clr_req = 0;
    pl_zero = 1'b1;
    repeat (3) @(negedge clk);
    pl_zero = 1'b0;
    checks++;
    if ({rd_data, rd_valid, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_data=%h rd_valid=%b clr_busy=%b mem_en=%b mem_we=%b addr=%h wdata=%h drop=%h, required all 0",
               rd_data, rd_valid, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, drop_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || clr_busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: mem_en=%b clr_busy=%b, required 0 0", mem_en, clr_busy);
    end
  endtask

  task automatic test_single_inc();
    logic [15:0] d; bit got;
    @(negedge clk); inc_valid = 1'b1; inc_addr = 8'h80;
    @(negedge clk); inc_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h80) begin
      errors++; $display("FAIL inc_read_cycle: en=%b we=%b addr=%h, required 1 0 80", mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h80 || mem_wdata !== 16'h0001) begin
      errors++; $display("FAIL inc_write_cycle: en=%b we=%b addr=%h wdata=%h, required 1 1 80 0001",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL inc_idle_after: en=%b we=%b, required 0 0", mem_en, mem_we);
    end
    host_read(8'h80, d, got);
    checks++;
    if (!got || d !== 16'h0001) begin
      errors++; $display("FAIL single_inc_read: got=%0b data=%h, required 1 0001", got, d);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_valid_pulse: rd_valid=%b one cycle later, required 0", rd_valid);
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] d; bit got;
    @(negedge clk);
    inc_valid = 1'b1; inc_addr = 8'h22; rd_req = 1'b1; rd_addr = 8'h22;
    @(negedge clk); inc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h22 || mem_wdata !== 16'h0001) begin
      errors++; $display("FAIL arb_inc_first: we=%b addr=%h wdata=%h, required 1 22 0001", mem_we, mem_addr, mem_wdata);
    end
    got = 1'b0; d = 'x;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin got = 1'b1; d = rd_data; rd_req = 1'b0; end
    end
    rd_req = 1'b0;
    checks++;
    if (!got || d !== 16'h0001) begin
      errors++; $display("FAIL arb_read_value: got=%0b data=%h, required 1 0001", got, d);
    end
  endtask

  task automatic test_burst_overflow();
    logic [15:0] d; bit got, ok;
    // Burst starts while a host read holds the RAM, so only one pop falls inside it.
    @(negedge clk); rd_req = 1'b1; rd_addr = 8'h10;
    @(negedge clk); rd_req = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin
      errors++; $display("FAIL burst_phase: en=%b we=%b addr=%h, required 1 0 10", mem_en, mem_we, mem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      inc_valid = 1'b1; inc_addr = 8'h85;
      @(negedge clk);
    end
    inc_valid = 1'b0;
    wait_quiet(ok);
    checks++;
    if (!ok || drop_cnt !== 16'd1) begin
      errors++; $display("FAIL burst_drop_cnt: quiet=%0b drop_cnt=%0d, required 1 1", ok, drop_cnt);
    end
    host_read(8'h85, d, got);
    checks++;
    if (!got || d !== 16'd5) begin
      errors++; $display("FAIL burst_bin_value: got=%0b data=%0d, required 1 5", got, d);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] d, exp; bit got, ok;
`ifdef HIST_SAT_EN
    exp = 16'hFFFF;
`else
    exp = 16'h0000;
`endif
    preload(8'h7F, 16'hFFFF);
    @(negedge clk); inc_valid = 1'b1; inc_addr = 8'h7F;
    @(negedge clk); inc_valid = 1'b0;
    wait_quiet(ok);
    host_read(8'h7F, d, got);
    checks++;
    if (!ok || !got || d !== exp) begin
      errors++; $display("FAIL wrap_sat: quiet=%0b got=%0b data=%h, required 1 1 %h", ok, got, d, exp);
    end
  endtask

  task automatic test_clear_mid_inc();
    logic [15:0] d; bit got; int bad;
    preload(8'h00, 16'd3);
    preload(8'hFF, 16'd7);
    preload(8'h40, 16'd9);
    @(negedge clk); inc_valid = 1'b1; inc_addr = 8'h30;
    @(negedge clk); inc_valid = 1'b0; clr_req = 1'b1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h30) begin
      errors++; $display("FAIL clr_in_inc_rd: en=%b we=%b addr=%h, required 1 0 30", mem_en, mem_we, mem_addr);
    end
    @(negedge clk); clr_req = 1'b0;
    checks++;
    if (clr_busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 16'd1) begin
      errors++; $display("FAIL clr_write_completes: busy=%b we=%b addr=%h wdata=%h, required 1 1 30 0001",
                         clr_busy, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || clr_busy !== 1'b1) begin
      errors++; $display("FAIL clr_idle_gap: en=%b busy=%b, required 0 1", mem_en, clr_busy);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== i[7:0] || mem_wdata !== 16'h0 || clr_busy !== 1'b1) begin
        errors++; bad++;
        if (bad <= 4)
          $display("FAIL clr_sweep[%0d]: en=%b we=%b addr=%h wdata=%h busy=%b, required 1 1 %h 0000 1",
                   i, mem_en, mem_we, mem_addr, mem_wdata, clr_busy, i[7:0]);
      end
      inc_valid = (i >= 10 && i < 20);
      inc_addr  = 8'h33;
      clr_req   = (i == 100);
    end
    inc_valid = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL clr_done: busy=%b en=%b, required 0 0", clr_busy, mem_en);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0 || drop_cnt !== 16'd1) begin
      errors++; $display("FAIL clr_ignored_req: busy=%b en=%b drop=%0d, required 0 0 1", clr_busy, mem_en, drop_cnt);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      host_read(i[7:0], d, got);
      checks++;
      if (!got || d !== 16'h0) begin
        errors++; bad++;
        if (bad <= 4) $display("FAIL clr_bin_zero[%0d]: got=%0b data=%h, required 1 0000", i, got, d);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [15:0] d; bit got, hit;
    preload(8'h60, 16'hABCD);
    preload(8'h55, 16'h1234);
    host_read(8'h55, d, got);
    checks++;
    if (!got || d !== 16'h1234) begin
      errors++; $display("FAIL preload_read: got=%0b data=%h, required 1 1234", got, d);
    end
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 8'h40) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rst_clear_reach40: reached=%0b, required 1", hit);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_data, rd_valid, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear_outputs: rd_data=%h rd_valid=%b busy=%b en=%b we=%b addr=%h wdata=%h drop=%h, required all 0",
               rd_data, rd_valid, clr_busy, mem_en, mem_we, mem_addr, mem_wdata, drop_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rst_release_idle: busy=%b en=%b, required 0 0", clr_busy, mem_en);
    end
    host_read(8'h60, d, got);
    checks++;
    if (!got || d !== 16'hABCD) begin
      errors++; $display("FAIL rst_sweep_stopped: got=%0b data=%h, required 1 abcd", got, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_arbitration();
    test_burst_overflow();
    test_wrap();
    test_clear_mid_inc();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
